serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator.sv | 150 +++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator. One bit pair is accepted per
// valid cycle; a one-cycle done pulse presents registered gt/lt/eq after the Nth pair.
module serial_magnitude_comparator #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic gt,
    output logic lt,
    output logic eq
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dec_q, dec_d;
    logic           igt_q, igt_d;
    logic           ilt_q, ilt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           gt_q, gt_d;
    logic           lt_q, lt_d;
    logic           eq_q, eq_d;

    // Decision flags including the pair presented this cycle (first difference wins).
    logic           dec_n_s, igt_n_s, ilt_n_s;

    // Fold the current bit pair into the running decision.
    always_comb begin
        dec_n_s = dec_q;
        igt_n_s = igt_q;
        ilt_n_s = ilt_q;
        if (!dec_q && (a_bit != b_bit)) begin
            dec_n_s = 1'b1;
            igt_n_s = a_bit;
            ilt_n_s = ~a_bit;
        end else begin
            dec_n_s = dec_q;
        end
    end

    // Next-state and output-register computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        igt_d   = igt_q;
        ilt_d   = ilt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPARE;
                    cnt_d   = '0;
                    dec_d   = 1'b0;
                    igt_d   = 1'b0;
                    ilt_d   = 1'b0;
                    busy_d  = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                if (start) begin
                    // Restart: the aborted operation never produces a done.
                    cnt_d  = '0;
                    dec_d  = 1'b0;
                    igt_d  = 1'b0;
                    ilt_d  = 1'b0;
                    busy_d = 1'b1;
                end else if (bit_valid) begin
                    dec_d = dec_n_s;
                    igt_d = igt_n_s;
                    ilt_d = ilt_n_s;
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        gt_d    = igt_n_s;
                        lt_d    = ilt_n_s;
                        eq_d    = ~dec_n_s;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = COMPARE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            igt_q   <= 1'b0;
            ilt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            igt_q   <= igt_d;
            ilt_q   <= ilt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: directed scenarios plus
// randomized operands checked against an arithmetic reference (A > B, A < B, A == B).
module tb_serial_magnitude_comparator;

    localparam int N = 8;

    logic clk;
    logic rst;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic gt;
    logic lt;
    logic eq;

    int checks;
    int errors;

    serial_magnitude_comparator #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic a, input logic b);
        start     = s;
        bit_valid = v;
        a_bit     = a;
        b_bit     = b;
    endtask

    // Stream both operands MSB first with `gap` idle cycles before each pair.
    // Counts early done pulses and busy drops seen before the final pair.
    task automatic stream(input logic [N-1:0] a, input logic [N-1:0] b, input int gap,
                          output int early_done, output int busy_drop);
        early_done = 0;
        busy_drop  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
                step();
                if (done)  early_done++;
                if (!busy) busy_drop++;
            end
            drive(1'b0, 1'b1, a[i], b[i]);
            step();
            if (i > 0) begin
                if (done)  early_done++;
                if (!busy) busy_drop++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_flags(input string name, input logic [2:0] exp);
        // exp = {gt, lt, eq}
        checks++;
        if ({gt, lt, eq} !== exp) begin
            errors++;
            $display("FAIL %s: got gt/lt/eq=%b expected %b", name, {gt, lt, eq}, exp);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a > b)      return 3'b100;
        else if (a < b) return 3'b010;
        else            return 3'b001;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        checks++;
        if ({busy, done, gt, lt, eq} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got busy/done/gt/lt/eq=%b expected 00000", {busy, done, gt, lt, eq});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({busy, done, gt, lt, eq} !== 5'b0) begin
            errors++;
            $display("FAIL after_reset: got %b expected 00000", {busy, done, gt, lt, eq});
        end
    endtask

    task automatic test_basic_gt();
        int ed, bd;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL gt_start: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        check_flags("gt_start_flags", 3'b000);
        stream(8'hA5, 8'h5A, 0, ed, bd);
        checks++;
        if (ed !== 0 || bd !== 0) begin
            errors++;
            $display("FAIL gt_stream: got early_done=%0d busy_drops=%0d expected 0 0", ed, bd);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gt_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        check_flags("gt_result", 3'b100);
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL gt_done_pulse: got done=%b expected 0", done);
        end
        check_flags("gt_hold", 3'b100);
    endtask

    task automatic test_equal();
        int ed, bd;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_flags("eq_cleared", 3'b000);
        stream(8'h3C, 8'h3C, 0, ed, bd);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL eq_done: got done=%b expected 1", done);
        end
        check_flags("eq_result", 3'b001);
        repeat (5) step();
        check_flags("eq_hold5", 3'b001);
    endtask

    task automatic test_gaps();
        int ed, bd;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        stream(8'h00, 8'hFF, 1, ed, bd);
        checks++;
        if (ed !== 0 || bd !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL gap_timing: got early_done=%0d busy_drops=%0d done=%b expected 0 0 1", ed, bd, done);
        end
        check_flags("gap_result", 3'b010);
    endtask

    task automatic test_abort();
        int ed, bd, spurious;
        logic [N-1:0] a_first;
        a_first  = 8'hA5;
        spurious = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            step();
            if (done) spurious++;
        end
        // Restart with a bit pair present; that pair must be ignored.
        drive(1'b1, 1'b1, a_first[7], 1'b0);
        step();
        if (done) spurious++;
        checks++;
        if (busy !== 1'b1 || spurious !== 0) begin
            errors++;
            $display("FAIL abort_restart: got busy=%b spurious_done=%0d expected 1 0", busy, spurious);
        end
        check_flags("abort_flags_clear", 3'b000);
        stream(8'h01, 8'h02, 0, ed, bd);
        checks++;
        if (ed !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_done: got early_done=%0d done=%b expected 0 1", ed, done);
        end
        check_flags("abort_result", 3'b010);
    endtask

    task automatic test_reset_mid();
        int bad;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            step();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, gt, lt, eq} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async: got busy/done/gt/lt/eq=%b expected 00000", {busy, done, gt, lt, eq});
        end
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
            step();
            if (done || busy) bad++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_no_start: got %0d cycles with busy/done expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int ed, bd;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        stream(8'h81, 8'h80, 0, ed, bd);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got done=%b expected 1", done);
        end
        check_flags("b2b_lsb_gt", 3'b100);
        // Start in the done cycle, with a bit pair that must be discarded.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got done=%b busy=%b expected 0 1", done, busy);
        end
        check_flags("b2b_cleared", 3'b000);
        stream(8'h80, 8'h81, 0, ed, bd);
        checks++;
        if (ed !== 0 || bd !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: got early=%0d drops=%0d done=%b expected 0 0 1", ed, bd, done);
        end
        check_flags("b2b_lsb_lt", 3'b010);
    endtask

    task automatic test_random();
        int ed, bd;
        logic [N-1:0] a, b;
        for (int t = 0; t < 24; t++) begin
            a = N'($urandom);
            b = (($urandom_range(3)) == 0) ? a : N'($urandom);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
            stream(a, b, int'($urandom_range(2)), ed, bd);
            checks++;
            if (ed !== 0 || bd !== 0 || done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_timing a=%h b=%h: got early=%0d drops=%0d done=%b busy=%b expected 0 0 1 0",
                         a, b, ed, bd, done, busy);
            end
            check_flags($sformatf("rand_result a=%h b=%h", a, b), ref_flags(a, b));
            repeat (int'($urandom_range(2))) step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        test_reset();
        test_basic_gt();
        test_equal();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
